// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//   CNT_W_DEF   : default ratio / period counter width
//   MIN_RATIO   : smallest usable divide ratio (ratios below it are raised to it)
//   clamp_ratio : maps a requested ratio to the ratio actually used
//   high_len    : high-phase length for a ratio; odd ratios give the extra cycle to the high phase
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam logic [31:0] MIN_RATIO = 32'd2;

  function automatic logic [31:0] clamp_ratio(input logic [31:0] n);
    return (n < MIN_RATIO) ? MIN_RATIO : n;
  endfunction

  function automatic logic [31:0] high_len(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, shadowed ratio, registered divided clock and tick.
// Ports:
//   clk      : system clock, posedge
//   resetn   : synchronous active-low reset
//   en       : run request
//   ratio    : requested divide ratio, sampled only at period start
//   sync     : restart pulse shared by all channels
//   div_clk  : registered divided clock
//   tick     : one-cycle strobe on each div_clk rising edge
//   running  : period in progress
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | stopped, all outputs low, cnt held at 0
// ST_RUN  | a period is in progress, cnt counts 0..act_n-1
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [CNT_W-1:0] ratio,
  input  logic             sync,
  output logic             div_clk,
  output logic             tick,
  output logic             running
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} ch_state_t;

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] act_n, act_n_nxt;
  logic             div_nxt, tick_nxt;

  logic [CNT_W-1:0] ratio_c;
  logic [CNT_W-1:0] high;
  logic [CNT_W-1:0] cnt_inc;
  logic             term;
  logic             start;

  assign running = (state == ST_RUN);
  assign ratio_c = CNT_W'(clamp_ratio(32'(ratio)));
  assign high    = CNT_W'(high_len(32'(act_n)));
  assign cnt_inc = cnt + CNT_W'(1);
  assign term    = running && (cnt == act_n - CNT_W'(1));
  // sync restarts a running channel even with en low; it then stops after that one period.
  assign start   = (!running && en) || (term && en) || (sync && (running || en));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      act_n   <= CNT_W'(MIN_RATIO);
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      act_n   <= act_n_nxt;
      div_clk <= div_nxt;
      tick    <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    act_n_nxt = act_n;
    div_nxt   = 1'b0;
    tick_nxt  = 1'b0;
    if (start) begin
      // The new ratio is only captured here, so a ratio change never cuts a period short.
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
      act_n_nxt = ratio_c;
      div_nxt   = 1'b1;
      tick_nxt  = 1'b1;
    end else if (term) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (running) begin
      cnt_nxt = cnt_inc;
      div_nxt = (cnt_inc < high);
    end else begin
      cnt_nxt = '0;
    end
  end

endmodule

// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider.
// Ports:
//   clk       : system clock, posedge
//   resetn    : synchronous active-low reset
//   en        : per-channel run request
//   div_ratio : per-channel divide ratio, channel i in [i*CNT_W +: CNT_W]
//   sync      : single-cycle pulse restarting all running/enabled channels in phase
//   div_clk   : per-channel registered divided clock
//   tick      : per-channel one-cycle strobe at each divided-period start
//   running   : per-channel period-in-progress flag
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] div_ratio,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       div_clk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       running
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .en      (en[i]),
      .ratio   (div_ratio[i*CNT_W +: CNT_W]),
      .sync    (sync),
      .div_clk (div_clk[i]),
      .tick    (tick[i]),
      .running (running[i])
    );
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
module tb_clk_divider_prog;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  en;
  logic [15:0] div_ratio;
  logic        sync;
  logic [1:0]  div_clk;
  logic [1:0]  tick;
  logic [1:0]  running;

  int total = 0;
  int bad   = 0;

  clk_divider_prog #(
    .NUM_CH (2),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .div_ratio (div_ratio),
    .sync      (sync),
    .div_clk   (div_clk),
    .tick      (tick),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps n cycles; first sample lands in the MSB of the n-bit result.
  task automatic capture(input int ch, input int n,
                         output logic [31:0] d, output logic [31:0] t, output logic [31:0] r);
    d = '0; t = '0; r = '0;
    for (int i = 0; i < n; i++) begin
      step();
      d = {d[30:0], div_clk[ch]};
      t = {t[30:0], tick[ch]};
      r = {r[30:0], running[ch]};
    end
  endtask

  initial begin
    logic [31:0] d, t, r, d1, t1, r1;
    int hi, first_low, ticks;

    resetn = 1'b0; en = 2'b00; div_ratio = 16'h0; sync = 1'b0;
    step(); step();
    check("reset_div_clk", 32'(div_clk), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    resetn = 1'b1;
    step();
    check("idle_outputs", {26'h0, div_clk, tick, running}, 32'h0);

    // Legacy equivalence: ch0 N=2, ch1 N=4
    div_ratio = {8'd4, 8'd2};
    en = 2'b11;
    capture(0, 8, d, t, r);
    check("legacy_div0", d, 32'b10101010);
    check("legacy_tick0", t, 32'b10101010);
    en = 2'b11;
    // second capture continues in phase: ch1 cnt continues from 3 -> restart
    capture(1, 8, d1, t1, r1);
    check("legacy_div1", d1, 32'b11001100);
    check("legacy_tick1", t1, 32'b10001000);
    en = 2'b00;
    step();
    check("legacy_stop_running", 32'(running), 32'h0);
    check("legacy_stop_div", 32'(div_clk), 32'h0);

    // Odd ratio 5 on ch0
    div_ratio = {8'd0, 8'd5};
    en = 2'b01;
    capture(0, 10, d, t, r);
    check("odd5_div", d, 32'b1110011100);
    check("odd5_tick", t, 32'b1000010000);
    check("odd5_ch1_idle", 32'(running[1]), 32'h0);
    en = 2'b00;
    step();
    check("odd5_stop", 32'(running[0]), 32'h0);

    // Clamp: ratio 0 on ch0, ratio 1 on ch1
    div_ratio = {8'd1, 8'd0};
    en = 2'b11;
    capture(0, 6, d, t, r);
    check("clamp0_div", d, 32'b101010);
    en = 2'b11;
    capture(1, 6, d1, t1, r1);
    check("clamp1_div", d1, 32'b101010);
    check("clamp1_tick", t1, 32'b101010);
    en = 2'b00;
    step();
    check("clamp_stop", 32'(running), 32'h0);

    // Ratio 255 on ch0: 128 high, 127 low
    div_ratio = {8'd0, 8'd255};
    en = 2'b01;
    hi = 0; first_low = -1; ticks = 0;
    for (int i = 0; i < 255; i++) begin
      step();
      if (div_clk[0]) hi++;
      else if (first_low < 0) first_low = i;
      if (tick[0]) ticks++;
    end
    check("r255_high", 32'(hi), 32'd128);
    check("r255_first_low", 32'(first_low), 32'd128);
    check("r255_ticks", 32'(ticks), 32'd1);
    step();
    check("r255_period", {30'h0, div_clk[0], tick[0]}, 32'b11);
    en = 2'b00;
    for (int i = 0; i < 254; i++) step();
    check("r255_last_cycle_running", 32'(running[0]), 32'h1);
    step();
    check("r255_stop", 32'(running[0]), 32'h0);

    // Shadowed ratio change: N=4, change to 6 at cnt=1
    div_ratio = {8'd0, 8'd4};
    en = 2'b01;
    step(); step();
    div_ratio = {8'd0, 8'd6};
    capture(0, 10, d, t, r);
    check("shadow_div", d, 32'b0011100011);
    check("shadow_tick", t, 32'b0010000010);

    // Graceful stop: now N=6 at cnt=1, drop en
    en = 2'b00;
    capture(0, 5, d, t, r);
    check("gstop_div", d, 32'b10000);
    check("gstop_running", r, 32'b11110);
    step();
    check("gstop_idle", {29'h0, div_clk[0], tick[0], running[0]}, 32'h0);
    en = 2'b01;
    step();
    check("gstop_restart", {29'h0, div_clk[0], tick[0], running[0]}, 32'b111);

    // Sync alignment: ch0 N=6 (running, cnt0), ch1 N=4 starts one cycle later
    div_ratio = {8'd4, 8'd6};
    en = 2'b11;
    step(); step();
    check("sync_pre_out_of_phase", 32'(tick), 32'h0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_div", 32'(div_clk), 32'b11);
    check("sync_tick", 32'(tick), 32'b11);
    check("sync_running", 32'(running), 32'b11);

    // Sync with en=0 on running ch1: one restart, then stop
    en = 2'b01;
    step(); // ch1 cnt1, ch0 cnt1
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_en0_restart", {30'h0, div_clk[1], tick[1]}, 32'b11);
    capture(1, 5, d, t, r);
    check("sync_en0_div", d, 32'b10000);
    check("sync_en0_running", r, 32'b11100);
    check("sync_en0_tick", t, 32'b00000);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_idle_ch_stays0", {30'h0, div_clk[1], running[1]}, 32'h0);
    check("sync_ch0_tick", 32'(tick[0]), 32'h1);

    // Reset mid-operation during ch0 high phase
    resetn = 1'b0;
    step();
    check("rst_mid_clear", {26'h0, div_clk, tick, running}, 32'h0);
    step();
    check("rst_mid_hold", {26'h0, div_clk, tick, running}, 32'h0);
    resetn = 1'b1;
    step();
    check("rst_release_start", {29'h0, div_clk[0], tick[0], running[0]}, 32'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
